// File: rtl/bitstream_pkg.sv
// Shared constants and helpers for the bitpacker / bit_unpacker pair.
package bitstream_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned BUF_W  = 64;
  localparam int unsigned FILL_W = 7;

  // Mask selecting the low len bits of a word; len >= WORD_W selects all of them.
  function automatic logic [WORD_W-1:0] lsb_mask(input logic [LEN_W-1:0] len);
    if (len >= LEN_W'(WORD_W)) begin
      return '1;
    end
    return (WORD_W'(1) << len) - WORD_W'(1);
  endfunction

endpackage

// File: rtl/bit_unpacker_shift64.sv
// Logarithmic right barrel shifter over the 64-bit bit buffer.
module bit_unpacker_shift64
  import bitstream_pkg::*;
(
  input  logic [BUF_W-1:0] data_i,
  input  logic [LEN_W-1:0] amt_i,
  output logic [BUF_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    for (int i = 0; i < int'(LEN_W); i++) begin
      if (amt_i[i]) begin
        data_o = data_o >> (1 << i);
      end
    end
  end

endmodule

// File: rtl/bit_unpacker.sv
// LSB-first field extractor: buffers packed words and lets the consumer peek
// 32 bits and retire a variable number of them per cycle.
module bit_unpacker #(
  parameter int unsigned BUF_W  = 64,
  parameter int unsigned WORD_W = 32
) (
  input  logic                               clock,
  input  logic                               nreset,
  input  logic                               word_in_valid,
  output logic                               word_in_ready,
  input  logic [WORD_W-1:0]                  word_in,
  output logic [WORD_W-1:0]                  data_out,
  output logic [bitstream_pkg::FILL_W-1:0]   bits_available,
  input  logic                               consume_valid,
  input  logic [bitstream_pkg::LEN_W-1:0]    consume_length,
  output logic                               underflow_error
);

  localparam int unsigned FillW = bitstream_pkg::FILL_W;
  localparam int unsigned LenW  = bitstream_pkg::LEN_W;

  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             err_q, err_d;

  logic             accept, cons, bad;
  logic [LenW-1:0]  len;
  logic [FillW-1:0] ins_amt;
  logic [BUF_W-1:0] shifted, inserted;

  // Ready depends on registered fill only, so a consume never feeds back into it.
  assign word_in_ready = (fill_q <= FillW'(WORD_W));
  assign accept        = word_in_valid & word_in_ready;
  assign cons          = consume_valid & (consume_length <= LenW'(WORD_W))
                         & ({1'b0, consume_length} <= fill_q);
  assign bad           = consume_valid & ~cons;
  assign len           = cons ? consume_length : '0;

  bit_unpacker_shift64 u_consume_shift (
    .data_i (buffer_q),
    .amt_i  (len),
    .data_o (shifted)
  );

  // fill - len is at most 32 whenever a word is accepted, so the word always fits.
  assign ins_amt  = fill_q - {1'b0, len};
  assign inserted = {{(BUF_W - WORD_W){1'b0}}, word_in} << ins_amt;

  always_comb begin
    buffer_d = shifted | (accept ? inserted : '0);
    fill_d   = fill_q - {1'b0, len} + (accept ? FillW'(WORD_W) : '0);
    err_d    = err_q | bad;
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      buffer_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      buffer_q <= buffer_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  assign data_out        = buffer_q[WORD_W-1:0];
  assign bits_available  = fill_q;
  assign underflow_error = err_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker: directed boundary cases plus a packed
// round trip checked through a field scoreboard.
module tb_bit_unpacker;
  import bitstream_pkg::*;

  logic        clock = 1'b0;
  logic        nreset;
  logic        word_in_valid;
  logic        word_in_ready;
  logic [31:0] word_in;
  logic [31:0] data_out;
  logic [6:0]  bits_available;
  logic        consume_valid;
  logic [5:0]  consume_length;
  logic        underflow_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] val;
    logic [5:0]  len;
  } field_t;

  field_t      fq[$];
  logic [31:0] wq[$];

  always #5 clock = ~clock;

  bit_unpacker #(
    .BUF_W  (64),
    .WORD_W (32)
  ) dut (
    .clock           (clock),
    .nreset          (nreset),
    .word_in_valid   (word_in_valid),
    .word_in_ready   (word_in_ready),
    .word_in         (word_in),
    .data_out        (data_out),
    .bits_available  (bits_available),
    .consume_valid   (consume_valid),
    .consume_length  (consume_length),
    .underflow_error (underflow_error)
  );

  // One clock with the given inputs; returns 1 ns after the edge with inputs idle.
  task automatic cyc(input logic v, input logic [31:0] w, input logic cv, input logic [5:0] cl);
    word_in_valid  = v;
    word_in        = w;
    consume_valid  = cv;
    consume_length = cl;
    @(posedge clock);
    #1;
    word_in_valid  = 1'b0;
    word_in        = '0;
    consume_valid  = 1'b0;
    consume_length = '0;
  endtask

  task automatic do_reset();
    nreset = 1'b1;
    cyc(1'b1, 32'hA5A5A5A5, 1'b0, 6'd0);
    cyc(1'b1, 32'h5A5A5A5A, 1'b0, 6'd0);
    nreset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bits_available !== 7'd0) $display("FAIL reset_bits: got %0d want 0", bits_available);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data_out);
    else pass_cnt++;
    total_cnt++;
    if (word_in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", word_in_ready);
    else pass_cnt++;
    total_cnt++;
    if (underflow_error !== 1'b0) $display("FAIL reset_err: got %b want 0", underflow_error);
    else pass_cnt++;
  endtask

  task automatic test_push_peek();
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 6'd0);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd32, 32'hDEADBEEF})
      $display("FAIL push: got %0d/%h want 32/deadbeef", bits_available, data_out);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 1'b1, 6'd4);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd28, 32'h0DEADBEE})
      $display("FAIL consume4: got %0d/%h want 28/0deadbee", bits_available, data_out);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 32'h12345678, 1'b1, 6'd8);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd52, 32'h678DEADB})
      $display("FAIL acc_cons: got %0d/%h want 52/678deadb", bits_available, data_out);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 1'b1, 6'd32);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd20, 32'h00012345})
      $display("FAIL consume32: got %0d/%h want 20/00012345", bits_available, data_out);
    else pass_cnt++;
  endtask

  task automatic test_full_cross_word();
    do_reset();
    cyc(1'b1, 32'hFFFFFFFF, 1'b0, 6'd0);
    cyc(1'b1, 32'h00000001, 1'b0, 6'd0);
    total_cnt++;
    if ({bits_available, word_in_ready} !== {7'd64, 1'b0})
      $display("FAIL full: got %0d/%b want 64/0", bits_available, word_in_ready);
    else pass_cnt++;
    cyc(1'b1, 32'hAAAAAAAA, 1'b0, 6'd0);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd64, 32'hFFFFFFFF})
      $display("FAIL full_hold: got %0d/%h want 64/ffffffff", bits_available, data_out);
    else pass_cnt++;
    // Word still offered: the consume must not let it in on the same edge.
    cyc(1'b1, 32'hAAAAAAAA, 1'b1, 6'd32);
    total_cnt++;
    if ({bits_available, data_out, word_in_ready} !== {7'd32, 32'h00000001, 1'b1})
      $display("FAIL cross: got %0d/%h/%b want 32/00000001/1",
               bits_available, data_out, word_in_ready);
    else pass_cnt++;
    cyc(1'b1, 32'hCAFEF00D, 1'b1, 6'd32);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd32, 32'hCAFEF00D})
      $display("FAIL swap32: got %0d/%h want 32/cafef00d", bits_available, data_out);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b1, 32'hABCDEF12, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd33);
    total_cnt++;
    if ({underflow_error, bits_available} !== {1'b1, 7'd32})
      $display("FAIL len33: got %b/%0d want 1/32", underflow_error, bits_available);
    else pass_cnt++;
    do_reset();
    cyc(1'b1, 32'hABCDEF12, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd27);
    cyc(1'b0, 32'h0, 1'b1, 6'd6);
    total_cnt++;
    if ({underflow_error, bits_available, data_out} !== {1'b1, 7'd5, 32'h15})
      $display("FAIL under6: got %b/%0d/%h want 1/5/00000015",
               underflow_error, bits_available, data_out);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 1'b1, 6'd5);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd0, 32'h0})
      $display("FAIL empty: got %0d/%h want 0/00000000", bits_available, data_out);
    else pass_cnt++;
    cyc(1'b1, 32'h11111111, 1'b1, 6'd3);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd32, 32'h11111111})
      $display("FAIL bad_accept: got %0d/%h want 32/11111111", bits_available, data_out);
    else pass_cnt++;
    cyc(1'b1, 32'h22222222, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd40);
    total_cnt++;
    if ({underflow_error, bits_available, data_out} !== {1'b1, 7'd64, 32'h11111111})
      $display("FAIL len40: got %b/%0d/%h want 1/64/11111111",
               underflow_error, bits_available, data_out);
    else pass_cnt++;
    cyc(1'b0, 32'h0, 1'b1, 6'd0);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd64, 32'h11111111})
      $display("FAIL len0: got %0d/%h want 64/11111111", bits_available, data_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    cyc(1'b1, 32'h01234567, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd24);
    cyc(1'b1, 32'h76543210, 1'b1, 6'd50);
    total_cnt++;
    if ({bits_available, underflow_error} !== {7'd40, 1'b1})
      $display("FAIL pre_reset: got %0d/%b want 40/1", bits_available, underflow_error);
    else pass_cnt++;
    nreset = 1'b1;
    cyc(1'b1, 32'hFEEDFACE, 1'b0, 6'd0);
    nreset = 1'b0;
    total_cnt++;
    if ({bits_available, underflow_error, data_out} !== {7'd0, 1'b0, 32'h0})
      $display("FAIL mid_reset: got %0d/%b/%h want 0/0/00000000",
               bits_available, underflow_error, data_out);
    else pass_cnt++;
    cyc(1'b1, 32'h89ABCDEF, 1'b0, 6'd0);
    cyc(1'b0, 32'h0, 1'b1, 6'd12);
    total_cnt++;
    if ({bits_available, data_out} !== {7'd20, 32'h00089ABC})
      $display("FAIL resume: got %0d/%h want 20/00089abc", bits_available, data_out);
    else pass_cnt++;
  endtask

  task automatic test_round_trip();
    logic [63:0] acc;
    int          acc_n;
    field_t      f;
    logic        acc_ok;
    int          cycles;
    do_reset();
    acc   = '0;
    acc_n = 0;
    for (int i = 0; i < 80; i++) begin
      f.len = 6'($urandom_range(0, 32));
      f.val = $urandom & lsb_mask(f.len);
      fq.push_back(f);
      acc   = acc | ({32'h0, f.val} << acc_n);
      acc_n = acc_n + int'(f.len);
      if (acc_n >= 32) begin
        wq.push_back(acc[31:0]);
        acc   = acc >> 32;
        acc_n = acc_n - 32;
      end
    end
    if (acc_n > 0) wq.push_back(acc[31:0]);
    cycles = 0;
    while (fq.size() > 0 && cycles < 3000) begin
      word_in_valid  = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
      word_in        = (wq.size() > 0) ? wq[0] : 32'h0;
      consume_valid  = 1'b0;
      consume_length = '0;
      if (bits_available >= {1'b0, fq[0].len} && $urandom_range(0, 4) != 0) begin
        f = fq.pop_front();
        if (f.len != 0) begin
          total_cnt++;
          if ((data_out & lsb_mask(f.len)) !== f.val)
            $display("FAIL field: got %h want %h len %0d",
                     data_out & lsb_mask(f.len), f.val, f.len);
          else pass_cnt++;
        end
        consume_valid  = 1'b1;
        consume_length = f.len;
      end
      acc_ok = word_in_valid && word_in_ready;
      @(posedge clock);
      #1;
      if (acc_ok) void'(wq.pop_front());
      cycles++;
    end
    word_in_valid  = 1'b0;
    consume_valid  = 1'b0;
    consume_length = '0;
    total_cnt++;
    if (fq.size() != 0) $display("FAIL rt_timeout: got %0d fields left want 0", fq.size());
    else pass_cnt++;
    total_cnt++;
    if (underflow_error !== 1'b0) $display("FAIL rt_err: got %b want 0", underflow_error);
    else pass_cnt++;
  endtask

  initial begin
    nreset         = 1'b1;
    word_in_valid  = 1'b0;
    word_in        = '0;
    consume_valid  = 1'b0;
    consume_length = '0;
    #1;
    test_reset();
    test_push_peek();
    test_simultaneous();
    test_full_cross_word();
    test_underflow();
    test_reset_mid_stream();
    test_round_trip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bit_unpacker.md
Name: bit_unpacker

Overview:
- Reads a stream of 32-bit words and returns variable-length fields of 0..32 bits, LSB-first.
- It is the inverse of the bitpacker: a field packed at bit offset k of a word is returned in data_out[len-1:0].
- It sits between the word-memory read side and the huffman/entropy decoder.
- The consumer peeks at the next 32 bits, then consumes the number of bits it decoded.

Parameters:
- BUF_W, 64, internal bit buffer width; must be 2*WORD_W.
- WORD_W, 32, input word width and maximum field length.

Ports:
- clock  input  1  clock.
- nreset  input  1  reset, synchronous, active-high.
- word_in_valid  input  1  word_in holds a valid word.
- word_in_ready  output  1  the block can accept a word this cycle.
- word_in  input  32  next packed word, LSB is earliest in the stream.
- data_out  output  32  next 32 stream bits, LSB-aligned; bits at and above bits_available read 0.
- bits_available  output  7  number of valid bits buffered, 0..64.
- consume_valid  input  1  consume consume_length bits this cycle.
- consume_length  input  6  bits to consume, 0..32.
- underflow_error  output  1  sticky error flag.

Behaviour:
- State: buf[63:0] and fill[6:0]. bits_available = fill. data_out = buf[31:0].
- Invariant: buf bits at index >= fill are always 0.
- Reset (nreset=1 at a clock edge):
  - buf=0, fill=0, underflow_error=0.
  - Resulting outputs: data_out=0, bits_available=0, word_in_ready=1.
  - Reset mid-operation discards all buffered bits. Any word offered in the reset cycle is not accepted.
- word_in_ready = (fill <= 32). It is a function of registered state only, with no combinational path from consume_*.
- accept = word_in_valid & word_in_ready.
- cons = consume_valid & (consume_length <= 32) & (consume_length <= fill).
- bad = consume_valid & !cons. On bad:
  - underflow_error is set and stays set until reset.
  - buf and fill are unchanged by the consume.
  - A simultaneous accept still happens.
- len = cons ? consume_length : 0. consume_length = 0 is a legal no-op.
- Next state, one cycle latency:
  - buf_next = (buf >> len) | (accept ? {32'h0, word_in} << (fill - len) : 0).
  - fill_next = fill - len + (accept ? 32 : 0).
  - The shift amount fill - len lies in 0..32, so the word always fits in 64 bits.
- Latency:
  - A word accepted at edge N is visible on data_out/bits_available after edge N.
  - A consume at edge N is reflected after edge N.
- Boundaries:
  - fill=64: ready=0. A same-cycle consume does not make the block ready until the next cycle.
  - fill=32 with accept and consume(32) together: fill_next=32, data_out=word_in.
  - fill=0: data_out=0. A consume of length > 0 is an underflow.
  - consume_length in 33..63 is always an underflow.
- Consumer rule: data_out[len-1:0] is a valid field only when bits_available >= len.
- No other states. No FSM beyond fill accounting.

Decomposition:
- Shared package bitstream_pkg holds:
  - WORD_W=32, LEN_W=6, BUF_W=64, FILL_W=7.
  - An LSB-mask helper constant/function shared with the bitpacker.
- One natural sub-module: a 64-bit right barrel shifter, bit_unpacker_shift64 (in, amt[5:0] -> out), instantiated for the consume shift.
- The insert shift stays inline.

Test Plan:
- Reset: hold nreset=1 for 2 cycles -> bits_available=0, data_out=0x00000000, word_in_ready=1, underflow_error=0.
- Push and peek: push 0xDEADBEEF -> next cycle bits_available=32, data_out=0xDEADBEEF. Then consume 4 -> bits_available=28, data_out=0x0DEADBEE.
- Simultaneous accept and consume:
  - Start from fill=28 (data_out=0x0DEADBEE).
  - In the same cycle push 0x12345678 and consume 8.
  - Expect bits_available=52, data_out=0x678DEADB. Then consume 32 -> bits_available=20, data_out=0x00012345.
- Full and cross-word:
  - Push 0xFFFFFFFF then 0x00000001 -> bits_available=64, word_in_ready=0. A third word held valid is not accepted.
  - Consume 32 -> data_out=0x00000001, bits_available=32, word_in_ready=1.
- Underflow:
  - With bits_available=5, consume 6 -> underflow_error=1 and bits_available stays 5.
  - Then consume 40 with fill 64 -> error stays 1 and fill is unchanged.
  - Consume 0 -> no change.
- Round trip and reset mid-stream:
  - Random bitpacker field sequences (lengths 0..32) fed back as words -> every consumed field matches the packed value masked to its length.
  - Assert nreset at fill=40 -> next cycle fill=0, error=0, and the stream resumes correctly.
